// File: rtl/mem_stage_access.sv
// -----------------------------------------------------------------------------
// mem_stage_access
// Memory-stage access controller between the E/M and M/W pipeline registers.
// It turns a load/store in the M stage into a req/ack data-memory transaction
// and holds the pipeline (StallM) until that transaction completes. Misaligned
// accesses and memory timeouts raise a sticky fault and never reach the bus.
//
// Ports
//   clk, rst                 pipeline clock, asynchronous active-high reset
//   MemtoRegM, MemWriteM     M-stage load / store request (store wins if both)
//   ALUResultM               byte address of the access
//   WriteDataM               store data
//   MemOut                   registered load data for the M/W register
//   StallM                   combinational stall for all stages up to M
//   mem_req/mem_we/mem_addr/mem_wdata   registered bus request outputs
//   mem_rdata, mem_ack       bus read data and one-cycle completion strobe
//   fault, fault_clr         sticky fault flag and its synchronous clear
// -----------------------------------------------------------------------------
module mem_stage_access #(
  parameter int          ADDR_W      = 10,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] FAULT_DATA  = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       MemOut,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              fault,
  input  logic              fault_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Counter value seen during the last REQ cycle before a timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         memout_q, memout_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                acc;
  logic                mis;
  logic                stall;
  logic                fault_set;

  // Only the word-address bits reach the bus; the rest is intentionally dropped.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^ALUResultM[31:ADDR_W+2];

  assign acc = MemtoRegM | MemWriteM;
  assign mis = acc & (ALUResultM[1:0] != 2'b00);

  // State register and bus/output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      memout_q <= 32'h0000_0000;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      memout_q <= memout_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, next-register values and the combinational stall.
  always_comb begin
    state_d   = state_q;
    memout_d  = memout_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    fault_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = acc;
        if (acc) begin
          if (mis) begin
            // Misaligned: flag it and complete without touching the bus.
            fault_set = 1'b1;
            if (!MemWriteM) begin
              memout_d = FAULT_DATA;
            end else begin
              memout_d = memout_q;
            end
            state_d = S_DONE;
          end else begin
            addr_d  = ALUResultM[ADDR_W+1:2];
            wdata_d = WriteDataM;
            we_d    = MemWriteM;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        // An ack in the final timeout cycle is checked first so it wins.
        if (mem_ack) begin
          if (!we_q) begin
            memout_d = mem_rdata;
          end else begin
            memout_d = memout_q;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_set = 1'b1;
          if (!we_q) begin
            memout_d = FAULT_DATA;
          end else begin
            memout_d = memout_q;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // mem_req is registered, so it follows the state being entered.
    req_d = (state_d == S_REQ);

    // A fault event in the same cycle as fault_clr keeps the flag set.
    if (fault_set) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  assign MemOut    = memout_q;
  assign StallM    = stall;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access
// Self-checking bench for mem_stage_access. The bench acts as the data memory
// (resp_mem) and keeps an independent transaction-level model (ref_mem,
// exp_memout, exp_fault) that predicts stall length, bus traffic and results.
// -----------------------------------------------------------------------------
module tb_mem_stage_access;

  localparam logic [31:0] FAULT_DATA = 32'hDEADBEEF;
  localparam int          TIMEOUT    = 16;
  localparam int          NO_ACK     = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] MemOut;
  logic        StallM;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        fault, fault_clr;

  int tests = 0;
  int fails = 0;

  logic [31:0] resp_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  logic [31:0] exp_memout;
  logic        exp_fault;

  mem_stage_access #(.ADDR_W(10), .TIMEOUT_CYC(16), .FAULT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemOut(MemOut), .StallM(StallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .fault(fault), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One M-stage instruction. ack_at = index of the REQ cycle that gets mem_ack
  // (0 = first REQ cycle); any value >= TIMEOUT means the memory never answers.
  task automatic access(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wd, input int ack_at, input logic fclr);
    int   stall_n = 0;
    int   req_n   = 0;
    int   exp_req;
    int   exp_stall;
    logic done    = 1'b0;
    logic is_acc, is_mis, acked;
    logic [9:0] w;
    is_acc = ld | st;
    is_mis = is_acc & (addr[1:0] != 2'b00);
    w      = addr[11:2];

    @(negedge clk);
    MemtoRegM = ld; MemWriteM = st; ALUResultM = addr; WriteDataM = wd;
    fault_clr = fclr; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cyc == 1) fault_clr = 1'b0;
      mem_ack = 1'b0;
      if (!StallM) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (mem_req) begin
          chk("bus_addr", {22'd0, mem_addr}, {22'd0, w});
          chk("bus_we", {31'd0, mem_we}, {31'd0, st});
          if (st) chk("bus_wdata", mem_wdata, wd);
          if (req_n == ack_at) begin
            mem_ack = 1'b1;
            if (mem_we) resp_mem[mem_addr] = mem_wdata;
            else        mem_rdata = resp_mem[mem_addr];
          end else begin
            mem_rdata = $urandom;
          end
          req_n++;
        end
      end
    end
    chk("completed", {31'd0, done}, 32'd1);

    // Reference model of the transaction outcome.
    if (is_acc && fclr) exp_fault = 1'b0;
    if (!is_acc) begin
      exp_req = 0; exp_stall = 0;
    end else if (is_mis) begin
      exp_req = 0; exp_stall = 1; exp_fault = 1'b1;
      if (!st) exp_memout = FAULT_DATA;
    end else begin
      acked     = (ack_at >= 0) && (ack_at < TIMEOUT);
      exp_req   = acked ? ack_at + 1 : TIMEOUT;
      exp_stall = 1 + exp_req;
      if (acked) begin
        if (st) ref_mem[w] = wd;
        else    exp_memout = ref_mem[w];
      end else begin
        exp_fault = 1'b1;
        if (!st) exp_memout = FAULT_DATA;
      end
    end
    chk("stall_cycles", stall_n, exp_stall);
    chk("req_cycles", req_n, exp_req);
    chk("memout", MemOut, exp_memout);
    chk("fault", {31'd0, fault}, {31'd0, exp_fault});
    chk("req_low_done", {31'd0, mem_req}, 32'd0);
    MemtoRegM = 1'b0; MemWriteM = 1'b0; fault_clr = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] v, r;
    logic [9:0]  rw;
    logic [1:0]  lo;
    int          kind;

    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      resp_mem[i] = v;
      ref_mem[i]  = v;
    end
    rst = 1'b1; MemtoRegM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'd0;
    WriteDataM = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0; fault_clr = 1'b0;
    exp_memout = 32'd0; exp_fault = 1'b0;

    // Reset state.
    #12;
    chk("rst_memout", MemOut, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed: load with immediate ack.
    resp_mem[4] = 32'hCAFEF00D; ref_mem[4] = 32'hCAFEF00D;
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0, 0, 1'b0);
    // Directed: store acked on the third REQ cycle, then read back.
    access(1'b0, 1'b1, 32'h0000_0008, 32'h12345678, 2, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0008, 32'd0, 1, 1'b0);
    // Directed: misaligned load, then clear the fault.
    access(1'b1, 1'b0, 32'h0000_0006, 32'd0, 0, 1'b0);
    access(1'b0, 1'b0, 32'h0000_0000, 32'd0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0, 0, 1'b1);
    // Directed: timeout, then ack in the last timeout cycle.
    access(1'b1, 1'b0, 32'h0000_0044, 32'd0, NO_ACK, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0048, 32'd0, TIMEOUT - 1, 1'b1);
    // Directed: load and store both set -> store; misaligned store with fault_clr.
    access(1'b1, 1'b1, 32'h0000_0050, 32'hA5A5_5A5A, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0050, 32'd0, 0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0053, 32'h1111_2222, 0, 1'b1);

    // Spurious ack while idle must change nothing.
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk); #1; mem_ack = 1'b0;
    chk("spurious_memout", MemOut, exp_memout);
    chk("spurious_req", {31'd0, mem_req}, 32'd0);
    chk("spurious_fault", {31'd0, fault}, {31'd0, exp_fault});

    // Asynchronous reset in the middle of a request.
    @(negedge clk); MemtoRegM = 1'b1; ALUResultM = 32'h0000_0020;
    @(negedge clk); #1;
    chk("midreq_req_up", {31'd0, mem_req}, 32'd1);
    #2; rst = 1'b1; MemtoRegM = 1'b0; #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_memout", MemOut, 32'd0);
    chk("arst_addr", {22'd0, mem_addr}, 32'd0);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    chk("arst_stall", {31'd0, StallM}, 32'd0);
    @(negedge clk); rst = 1'b0;
    exp_memout = 32'd0; exp_fault = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0020, 32'd0, 0, 1'b0);

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      r    = $urandom;
      rw   = 10'($urandom_range(0, 63));
      lo   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      access(kind[0], kind[1], {r[31:12], rw, lo}, $urandom,
             $urandom_range(0, 17), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
